// File: rtl/data_bus_responder.sv
// Data-side SRAM responder: word RAM plus LED/NUM/SWITCH/TIMER MMIO.
// One access per cycle, rdata registered with one-cycle latency.
module data_bus_responder #(
    parameter int          RAM_AW  = 14,
    parameter logic [15:0] MMIO_HI = 16'hbfaf
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_wen,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    input  logic [7:0]  switch,
    output logic [15:0] led,
    output logic [31:0] num_data,
    output logic        timer_int
);

    localparam logic [15:0] OFF_LED   = 16'hf000;
    localparam logic [15:0] OFF_NUM   = 16'hf010;
    localparam logic [15:0] OFF_SW    = 16'hf020;
    localparam logic [15:0] OFF_TIMER = 16'he000;
    localparam logic [15:0] OFF_CMP   = 16'he004;

    logic [31:0] mem [2**RAM_AW];

    logic [RAM_AW-1:0] idx;
    logic [15:0]       off;
    logic              mmio_sel;
    logic              ram_wr;
    logic              mmio_wr;
    logic              led_we;
    logic              num_we;
    logic              timer_we;
    logic              cmp_we;

    logic [7:0]  sw_q1;
    logic [7:0]  sw_q2;
    logic [31:0] timer;
    logic [31:0] compare;
    logic [31:0] mmio_rd;

    assign idx      = data_sram_addr[RAM_AW+1:2];
    assign off      = data_sram_addr[15:0];
    assign mmio_sel = (data_sram_addr[31:16] == MMIO_HI);

    assign ram_wr  = data_sram_en && !mmio_sel && (data_sram_wen != 4'h0);
    assign mmio_wr = data_sram_en && mmio_sel && (data_sram_wen == 4'hf);

    assign led_we   = mmio_wr && (off == OFF_LED);
    assign num_we   = mmio_wr && (off == OFF_NUM);
    assign timer_we = mmio_wr && (off == OFF_TIMER);
    assign cmp_we   = mmio_wr && (off == OFF_CMP);

    always_comb begin
        mmio_rd = 32'h0;
        unique case (1'b1)
            (off == OFF_LED):   mmio_rd = {16'h0, led};
            (off == OFF_NUM):   mmio_rd = num_data;
            (off == OFF_SW):    mmio_rd = {24'h0, sw_q2};
            (off == OFF_TIMER): mmio_rd = timer;
            (off == OFF_CMP):   mmio_rd = compare;
            default:            mmio_rd = 32'h0;
        endcase
    end

    // Reset aborts an in-flight write, so the commit is gated here too.
    always_ff @(posedge clk) begin
        if (!reset && ram_wr) begin
            for (int i = 0; i < 4; i++) begin
                if (data_sram_wen[i]) begin
                    mem[idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_sram_rdata <= 32'h0;
        end else if (data_sram_en) begin
            data_sram_rdata <= mmio_sel ? mmio_rd : mem[idx];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sw_q1 <= 8'h0;
            sw_q2 <= 8'h0;
        end else begin
            sw_q1 <= switch;
            sw_q2 <= sw_q1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            led      <= 16'h0;
            num_data <= 32'h0;
            compare  <= 32'h0;
        end else begin
            if (led_we) led <= data_sram_wdata[15:0];
            if (num_we) num_data <= data_sram_wdata;
            if (cmp_we) compare <= data_sram_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            timer <= 32'h0;
        end else if (timer_we) begin
            timer <= data_sram_wdata;
        end else begin
            timer <= timer + 32'd1;
        end
    end

    // A COMPARE write takes priority over a match in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            timer_int <= 1'b0;
        end else if (cmp_we) begin
            timer_int <= 1'b0;
        end else if ((timer == compare) && (compare != 32'h0)) begin
            timer_int <= 1'b1;
        end
    end

endmodule
